// File: rtl/counter_register_pair_if.sv
// Bus bundle for counter_register_pair: counter load/increment controls and
// register capture controls in; counter value, terminal count and register value out.
interface counter_register_pair_if #(
  parameter int WIDTH  = 4,
  parameter int DWIDTH = 4
);
  logic [WIDTH-1:0]  cnt_d;
  logic              cnt_load;
  logic              cnt_up;
  logic [WIDTH-1:0]  cnt_q;
  logic              cnt_tc;
  logic [DWIDTH-1:0] reg_d;
  logic              reg_en;
  logic [DWIDTH-1:0] reg_q;

  modport master (
    output cnt_d, cnt_load, cnt_up, reg_d, reg_en,
    input  cnt_q, cnt_tc, reg_q
  );

  modport slave (
    input  cnt_d, cnt_load, cnt_up, reg_d, reg_en,
    output cnt_q, cnt_tc, reg_q
  );
endinterface

// File: rtl/counter_register_pair.sv
// Loadable wrapping up-counter plus independent enabled holding register; one-cycle latency.
// No backpressure: every input is sampled each posedge, and reset overrides every other input.
module counter_register_pair #(
  parameter int                WIDTH   = 4,
  parameter int                DWIDTH  = 4,
  parameter logic [WIDTH-1:0]  CNT_RST = '0,
  parameter logic [DWIDTH-1:0] REG_RST = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  counter_register_pair_if.slave  bus
);

  logic [WIDTH-1:0]  cnt_q;
  logic [DWIDTH-1:0] reg_q;

  // rst_n is active-high despite its name; load has priority over increment.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= CNT_RST;
    end else if (bus.cnt_load) begin
      cnt_q <= bus.cnt_d;
    end else if (bus.cnt_up) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      reg_q <= REG_RST;
    end else if (bus.reg_en) begin
      reg_q <= bus.reg_d;
    end
  end

  assign bus.cnt_q  = cnt_q;
  assign bus.cnt_tc = &cnt_q;
  assign bus.reg_q  = reg_q;

endmodule

// File: tb/tb_counter_register_pair.sv
// Directed bench for counter_register_pair at WIDTH=DWIDTH=4 with zero reset values.
module tb_counter_register_pair;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   m;

  counter_register_pair_if #(.WIDTH(4), .DWIDTH(4)) bus ();

  counter_register_pair #(
    .WIDTH   (4),
    .DWIDTH  (4),
    .CNT_RST (4'h0),
    .REG_RST (4'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] exp_q);
    check({tag, ".cnt_q"}, {28'd0, bus.cnt_q}, {28'd0, exp_q});
    check({tag, ".cnt_tc"}, {31'd0, bus.cnt_tc}, {31'd0, (exp_q == 4'hF)});
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Reset with junk on every other input
    rst_n        = 1'b1;
    bus.cnt_d    = 4'hC;
    bus.cnt_load = 1'b1;
    bus.cnt_up   = 1'b1;
    bus.reg_d    = 4'hB;
    bus.reg_en   = 1'b1;
    step();
    check_cnt("reset", 4'h0);
    check("reset.reg_q", {28'd0, bus.reg_q}, 32'h0);

    // Idle with X on unused data inputs must hold
    rst_n        = 1'b0;
    bus.cnt_load = 1'b0;
    bus.cnt_up   = 1'b0;
    bus.reg_en   = 1'b0;
    bus.cnt_d    = 'x;
    bus.reg_d    = 'x;
    step();
    check_cnt("idle_x", 4'h0);
    check("idle_x.reg_q", {28'd0, bus.reg_q}, 32'h0);

    // Count through full range and wrap
    bus.cnt_up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check_cnt($sformatf("count%0d", i), 4'(i % 16));
    end

    // Load priority over increment
    bus.cnt_up   = 1'b0;
    bus.cnt_load = 1'b1;
    bus.cnt_d    = 4'h7;
    step();
    check_cnt("load7", 4'h7);
    bus.cnt_up = 1'b1;
    bus.cnt_d  = 4'h3;
    step();
    check_cnt("load_wins", 4'h3);
    bus.cnt_load = 1'b0;
    bus.cnt_up   = 1'b0;
    bus.cnt_d    = 'x;
    step();
    check_cnt("hold3a", 4'h3);
    step();
    check_cnt("hold3b", 4'h3);

    // Slot clear idiom: 0,1,2,3,0,1,...
    bus.cnt_load = 1'b1;
    bus.cnt_d    = 4'h0;
    step();
    check_cnt("slot_init", 4'h0);
    m = 0;
    for (int i = 0; i < 10; i++) begin
      bus.cnt_up   = (m != 3);
      bus.cnt_load = (m == 3);
      bus.cnt_d    = 4'h0;
      step();
      m = (m == 3) ? 0 : m + 1;
      check_cnt($sformatf("slot%0d", i), 4'(m));
    end
    bus.cnt_up   = 1'b0;
    bus.cnt_load = 1'b0;

    // Register capture / hold / capture
    bus.reg_d  = 4'hA;
    bus.reg_en = 1'b1;
    step();
    check("reg_capA", {28'd0, bus.reg_q}, 32'hA);
    bus.reg_d  = 4'h5;
    bus.reg_en = 1'b0;
    step();
    check("reg_holdA", {28'd0, bus.reg_q}, 32'hA);
    bus.reg_en = 1'b1;
    step();
    check("reg_cap5", {28'd0, bus.reg_q}, 32'h5);

    // Reset mid-operation with both halves active
    bus.cnt_load = 1'b1;
    bus.cnt_d    = 4'h8;
    step();
    check_cnt("pre_load8", 4'h8);
    bus.cnt_load = 1'b0;
    bus.cnt_up   = 1'b1;
    bus.reg_d    = 4'hA;
    bus.reg_en   = 1'b1;
    step();
    check_cnt("at9", 4'h9);
    check("at9.reg_q", {28'd0, bus.reg_q}, 32'hA);
    rst_n      = 1'b1;
    bus.reg_d  = 4'h6;
    step();
    check_cnt("midrst", 4'h0);
    check("midrst.reg_q", {28'd0, bus.reg_q}, 32'h0);
    rst_n      = 1'b0;
    bus.reg_en = 1'b0;
    step();
    check_cnt("resume1", 4'h1);
    check("resume1.reg_q", {28'd0, bus.reg_q}, 32'h0);
    step();
    check_cnt("resume2", 4'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
